// File: rtl/mmio_router.sv
// mmio_router: routes one outstanding LSU request to either the D-cache or the uncached arbiter port,
// decided by NUM_WIN MMIO address windows. Define ysyx22040228_MMIO_TIMEOUT_EN to abort hung MMIO accesses.
module mmio_router #(
  parameter int                      NUM_WIN     = 2,
  parameter logic [NUM_WIN*64-1:0]   WIN_BASE    = {64'ha0000048, 64'ha00003f8},
  parameter logic [NUM_WIN*64-1:0]   WIN_LIMIT   = {64'ha000004f, 64'ha00003ff},
  parameter int                      TIMEOUT_CYC = 1023
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [63:0]        core_addr,
  input  logic [63:0]        core_data,
  input  logic [7:0]         core_mask,
  input  logic               core_we,
  input  logic               core_re,
  input  logic               fence_in,
  output logic [63:0]        in_core_data,
  output logic               in_core_finish,
  output logic               core_err,
  output logic [NUM_WIN-1:0] mmio_sign,
  output logic [63:0]        arb_addr,
  output logic [63:0]        arb_data,
  output logic [7:0]         arb_mask,
  output logic               arb_we,
  output logic               arb_re,
  input  logic [63:0]        in_arb_data,
  input  logic               in_arb_finish,
  output logic [63:0]        dcache_addr,
  output logic [63:0]        dcache_data,
  output logic [7:0]         dcache_mask,
  output logic               dcache_we,
  output logic               dcache_re,
  output logic               dcache_fence,
  input  logic [63:0]        in_dcache_data,
  input  logic               in_dcache_finish
);

  // Handshake: the core holds we/re (acts as valid) until in_core_finish; a downstream port
  // holds its request fields stable until it returns a one-cycle finish (acts as ready+response).
  typedef enum logic [1:0] {IDLE, MMIO, CACHE, RESP} state_t;

  state_t              state;
  state_t              state_nxt;

  logic [63:0]         addr_q;
  logic [63:0]         data_q;
  logic [63:0]         rdata_q;
  logic [7:0]          mask_q;
  logic                we_q;
  logic                re_q;
  logic                err_q;
  logic [NUM_WIN-1:0]  hit_q;
  logic                fence_pend;

  logic [NUM_WIN-1:0]  hit;
  logic [63:0]         masked_data;
  logic                req;
  logic                fence_now;
  logic                accept;
  logic                expire;

  // Walk from the top index down so the lowest overlapping window is the last writer.
  always_comb begin
    hit = '0;
    for (int i = NUM_WIN - 1; i >= 0; i--) begin
      if ((core_addr >= WIN_BASE[64*i +: 64]) && (core_addr <= WIN_LIMIT[64*i +: 64])) begin
        hit    = '0;
        hit[i] = 1'b1;
      end
    end
  end

  always_comb begin
    masked_data = '0;
    for (int k = 0; k < 8; k++) begin
      masked_data[8*k +: 8] = core_mask[k] ? core_data[8*k +: 8] : 8'h00;
    end
  end

  assign req       = core_we | core_re;
  assign fence_now = fence_in | fence_pend;
  assign accept    = (state == IDLE) && req && !fence_now;

`ifdef ysyx22040228_MMIO_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  logic [16:0] tmo_next;

  assign tmo_next = {1'b0, tmo_cnt} + 17'd1;
  assign expire   = (state == MMIO) && !in_arb_finish && (tmo_next >= 17'(TIMEOUT_CYC));

  always_ff @(posedge clk) begin
    if (!rst) begin
      tmo_cnt <= '0;
    end else if (accept) begin
      tmo_cnt <= '0;
    end else if (state == MMIO) begin
      tmo_cnt <= tmo_next[15:0];
    end
  end
`else
  logic [31:0] unused_tmo;

  assign unused_tmo = 32'(TIMEOUT_CYC);
  assign expire     = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (|hit) ? MMIO : CACHE;
      MMIO:    if (in_arb_finish || expire) state_nxt = RESP;
      CACHE:   if (in_dcache_finish) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      rdata_q    <= '0;
      mask_q     <= '0;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      err_q      <= 1'b0;
      hit_q      <= '0;
      fence_pend <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        addr_q <= core_addr;
        mask_q <= core_mask;
        we_q   <= core_we;
        re_q   <= core_re & ~core_we;
        hit_q  <= hit;
        data_q <= (|hit) ? masked_data : core_data;
        err_q  <= 1'b0;
      end
      if (state == MMIO) begin
        if (in_arb_finish) begin
          rdata_q <= in_arb_data;
          err_q   <= 1'b0;
        end else if (expire) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end
      end
      if ((state == CACHE) && in_dcache_finish) begin
        rdata_q <= in_dcache_data;
      end
      // Any fence seen in IDLE is issued that cycle; otherwise it waits for IDLE.
      if (state == IDLE) begin
        fence_pend <= 1'b0;
      end else if (fence_in) begin
        fence_pend <= 1'b1;
      end
    end
  end

  always_comb begin
    arb_addr     = '0;
    arb_data     = '0;
    arb_mask     = '0;
    arb_we       = 1'b0;
    arb_re       = 1'b0;
    dcache_addr  = '0;
    dcache_data  = '0;
    dcache_mask  = '0;
    dcache_we    = 1'b0;
    dcache_re    = 1'b0;
    dcache_fence = (state == IDLE) && fence_now;
    if (state == MMIO) begin
      arb_addr = addr_q;
      arb_data = data_q;
      arb_mask = mask_q;
      arb_we   = we_q;
      arb_re   = re_q;
    end
    if (state == CACHE) begin
      dcache_addr = addr_q;
      dcache_data = data_q;
      dcache_mask = mask_q;
      dcache_we   = we_q;
      dcache_re   = re_q;
    end
  end

  assign in_core_finish = (state == RESP);
  assign in_core_data   = (state == RESP) ? rdata_q : 64'd0;
  assign core_err       = (state == RESP) && err_q;
  assign mmio_sign      = ((state == MMIO) || (state == RESP)) ? hit_q : '0;

endmodule
